// File: rtl/fifo_stream_drain.sv
// Purpose: converts a register-file FIFO pop/pending interface into a valid/ready stream via a 3-entry skid buffer.
// Latency: 2 cycles from o_fifo_pop to o_valid; sustains 1 word/clk once primed.
// Backpressure: i_ready never reaches o_fifo_pop combinationally; pops stop when buffered + in-flight words would exceed 3.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_en, i_flush             run enable (level), flush (1-cycle pulse)
//   i_fifo_pndng/i_fifo_data  FIFO not-empty flag and registered read data
//   o_fifo_pop                pop request to the FIFO
//   o_valid/o_data/i_ready    downstream stream handshake
//   o_busy, o_word_cnt        activity flag, saturating delivered-word count
module fifo_stream_drain #(
    parameter int WS = 16,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic          i_fifo_pndng,
    input  logic [WS-1:0] i_fifo_data,
    output logic          o_fifo_pop,
    output logic          o_valid,
    output logic [WS-1:0] o_data,
    input  logic          i_ready,
    output logic          o_busy,
    output logic [CW-1:0] o_word_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state;
    logic [1:0]    count;
    logic [1:0]    rd_ptr;
    logic [1:0]    wr_ptr;
    logic          inflight;
    logic          drop;
    logic [WS-1:0] mem [3];

    logic [2:0]    occ;
    logic          arrive;
    logic          xfer;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Occupancy includes the word already requested, so a pop is only
    // issued when there is guaranteed room for its data next cycle.
    assign occ        = {1'b0, count} + {2'b00, inflight};
    assign o_fifo_pop = (state == RUN) && !i_flush && i_fifo_pndng && (occ <= 3'd2);
    assign o_valid    = (count != 2'd0) && (state != FLUSH);
    assign o_busy     = (count != 2'd0) || inflight;
    assign arrive     = inflight && !drop;
    assign xfer       = o_valid && i_ready;

    always_comb begin
        o_data = mem[0];
        if (rd_ptr == 2'd1) o_data = mem[1];
        if (rd_ptr == 2'd2) o_data = mem[2];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            count      <= 2'd0;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            inflight   <= 1'b0;
            drop       <= 1'b0;
            o_word_cnt <= '0;
            for (int i = 0; i < 3; i++) mem[i] <= '0;
        end else begin
            inflight <= o_fifo_pop;

            case (state)
                IDLE:    if (i_flush) state <= FLUSH; else if (i_en)  state <= RUN;
                RUN:     if (i_flush) state <= FLUSH; else if (!i_en) state <= IDLE;
                FLUSH:   state <= i_en ? RUN : IDLE;
                default: state <= IDLE;
            endcase

            if (i_flush) begin
                // Anything buffered or landing on this edge is discarded.
                count  <= 2'd0;
                rd_ptr <= 2'd0;
                wr_ptr <= 2'd0;
                drop   <= inflight || o_fifo_pop;
            end else begin
                drop <= 1'b0;
                if (arrive) begin
                    for (int i = 0; i < 3; i++)
                        if (wr_ptr == i[1:0]) mem[i] <= i_fifo_data;
                    wr_ptr <= ptr_next(wr_ptr);
                end
                if (xfer) rd_ptr <= ptr_next(rd_ptr);
                case ({arrive, xfer})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end

            if (xfer && (o_word_cnt != '1)) o_word_cnt <= o_word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Purpose: directed self-checking bench for fifo_stream_drain with a behavioural FIFO in front.
// Latency: FIFO model returns popped data on the edge after the pop, like the real register-file FIFO.
// Backpressure: i_ready is driven per scenario; a CW=3 copy of the block shares all inputs to exercise counter saturation.
module tb_fifo_stream_drain;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_en;
    logic        i_flush;
    logic        i_fifo_pndng;
    logic [15:0] i_fifo_data;
    logic        i_ready;
    logic        o_fifo_pop;
    logic        o_valid;
    logic [15:0] o_data;
    logic        o_busy;
    logic [15:0] o_word_cnt;

    logic        s_pop;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_busy;
    logic [2:0]  s_word_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pop_n   = 0;
    int          ovf     = 0;
    logic [15:0] q   [$];
    logic [15:0] got [$];

    always #5 i_clk = ~i_clk;

    fifo_stream_drain #(.WS(16), .CW(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_flush(i_flush),
        .i_fifo_pndng(i_fifo_pndng), .i_fifo_data(i_fifo_data),
        .o_fifo_pop(o_fifo_pop), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready), .o_busy(o_busy), .o_word_cnt(o_word_cnt)
    );

    fifo_stream_drain #(.WS(16), .CW(3)) sat_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_flush(i_flush),
        .i_fifo_pndng(i_fifo_pndng), .i_fifo_data(i_fifo_data),
        .o_fifo_pop(s_pop), .o_valid(s_valid), .o_data(s_data),
        .i_ready(i_ready), .o_busy(s_busy), .o_word_cnt(s_word_cnt)
    );

    // A word landing in a full buffer with nothing leaving must never happen.
    always @(posedge i_clk)
        if (i_rst_n && !i_flush && dut.inflight && !dut.drop && dut.count == 2'd3 && !(o_valid && i_ready))
            ovf++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: FIFO model and stream monitor sample pre-edge values.
    task automatic tick();
        @(posedge i_clk);
        if (o_valid && i_ready) got.push_back(o_data);
        if (o_fifo_pop) begin
            pop_n++;
            if (q.size() != 0) i_fifo_data <= q.pop_front();
        end
        i_fifo_pndng <= (q.size() != 0);
        @(negedge i_clk);
    endtask

    task automatic push(input logic [15:0] w);
        q.push_back(w);
        i_fifo_pndng = 1'b1;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("wait_words", 32'(got.size()), 32'(n));
    endtask

    initial begin
        int pn;
        i_rst_n = 1'b0; i_en = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_fifo_pndng = 1'b0; i_fifo_data = 16'h0;
        #3;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_pop",   32'(o_fifo_pop), 0);
        check("rst_busy",  32'(o_busy), 0);
        check("rst_cnt",   32'(o_word_cnt), 0);
        check("rst_data",  32'(o_data), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // 1: three words, back-to-back delivery, 2-cycle pop-to-valid
        push(16'hA001); push(16'hA002); push(16'hA003);
        i_en = 1'b1; i_ready = 1'b1;
        tick(); check("t1_pop_first", 32'(o_fifo_pop), 1); check("t1_nv1", 32'(o_valid), 0);
        tick(); check("t1_nv2", 32'(o_valid), 0);
        tick(); check("t1_v1", 32'(o_valid), 1); check("t1_d1", 32'(o_data), 32'hA001);
        tick(); check("t1_d2", 32'(o_data), 32'hA002); check("t1_pop_end", 32'(o_fifo_pop), 0);
        tick(); check("t1_d3", 32'(o_data), 32'hA003); check("t1_busy_hi", 32'(o_busy), 1);
        tick(); check("t1_nv_end", 32'(o_valid), 0); check("t1_busy_lo", 32'(o_busy), 0);
        check("t1_cnt", 32'(o_word_cnt), 3);

        // 2: backpressure fills the buffer with exactly three pops
        i_ready = 1'b0; got.delete(); pn = pop_n;
        for (int i = 0; i < 6; i++) push(16'hB001 + 16'(i));
        repeat (6) tick();
        check("t2_pops", 32'(pop_n - pn), 3);
        check("t2_pop_lo", 32'(o_fifo_pop), 0);
        check("t2_head", 32'(o_data), 32'hB001);
        i_ready = 1'b1;
        wait_got(6, 30);
        for (int i = 0; i < 6; i++) check("t2_order", 32'(got[i]), 32'hB001 + i);
        check("t2_cnt", 32'(o_word_cnt), 9);
        check("t2_sat", 32'(s_word_cnt), 7);

        // 3: continuous stream, one word per clock
        got.delete();
        for (int i = 0; i < 20; i++) push(16'hE000 + 16'(i));
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_pop", 32'(o_fifo_pop), 1);
            check("t3_valid", 32'(o_valid), 1);
        end
        wait_got(20, 40);
        for (int i = 0; i < 20; i++) check("t3_order", 32'(got[i]), 32'hE000 + i);
        check("t3_cnt", 32'(o_word_cnt), 29);
        check("t3_busy", 32'(o_busy), 0);

        // 4: flush with two buffered and one in flight
        i_ready = 1'b0; got.delete();
        for (int i = 0; i < 5; i++) push(16'hC001 + 16'(i));
        repeat (3) tick();
        check("t4_pre_busy", 32'(o_busy), 1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("t4_nv", 32'(o_valid), 0);
        check("t4_busy", 32'(o_busy), 0);
        check("t4_cnt_keep", 32'(o_word_cnt), 29);
        i_ready = 1'b1;
        wait_got(2, 20);
        check("t4_first", 32'(got[0]), 32'hC004);
        check("t4_second", 32'(got[1]), 32'hC005);
        check("t4_cnt", 32'(o_word_cnt), 31);

        // 5: disable with words buffered, they still drain
        i_ready = 1'b0; got.delete(); pn = pop_n;
        for (int i = 0; i < 4; i++) push(16'hD001 + 16'(i));
        tick();
        i_en = 1'b0;
        repeat (4) tick();
        check("t5_pops", 32'(pop_n - pn), 2);
        check("t5_pop_lo", 32'(o_fifo_pop), 0);
        check("t5_head", 32'(o_data), 32'hD001);
        i_ready = 1'b1;
        wait_got(2, 10);
        check("t5_w0", 32'(got[0]), 32'hD001);
        check("t5_w1", 32'(got[1]), 32'hD002);
        tick();
        check("t5_busy", 32'(o_busy), 0);
        check("t5_idle_pop", 32'(o_fifo_pop), 0);
        check("t5_cnt", 32'(o_word_cnt), 33);
        check("t5_sat", 32'(s_word_cnt), 7);

        // 6: async reset mid-stream with two words buffered
        i_en = 1'b1; i_ready = 1'b0;
        repeat (4) tick();
        check("t6_pre_valid", 32'(o_valid), 1);
        check("t6_pre_head", 32'(o_data), 32'hD003);
        #2 i_rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(o_valid), 0);
        check("t6_pop",   32'(o_fifo_pop), 0);
        check("t6_busy",  32'(o_busy), 0);
        check("t6_cnt",   32'(o_word_cnt), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        check("no_overflow", 32'(ovf), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
